// File: rtl/control_maxpool_kxk_pkg.sv
// maxpool_pkg: shared FSM state type, default geometry and index-width helper
// Used by the interface and the top so port widths always agree.
package maxpool_pkg;
   typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
   localparam int DEF_WIDTH    = 5;
   localparam int DEF_HEIGHT   = 5;
   localparam int DEF_TREE_LAT = 2;
   // Counter width for a range of n values; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/control_maxpool_kxk_if.sv
// control_maxpool_kxk_if: pixel-stream control bus for the KxK max-pool controller
// master drives valid_in/clear; slave returns window/pipeline enables,
// pooled-valid, frame position, busy and frame_done.
interface control_maxpool_kxk_if
   import maxpool_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int TREE_LAT = DEF_TREE_LAT
);
   logic                     valid_in;
   logic                     clear;
   logic                     valid_out_line;
   logic [TREE_LAT-1:0]      tree_en;
   logic                     valid_out;
   logic [idx_w(WIDTH)-1:0]  col_idx;
   logic [idx_w(HEIGHT)-1:0] row_idx;
   logic                     busy;
   logic                     frame_done;
   modport master (
      output valid_in, clear,
      input  valid_out_line, tree_en, valid_out, col_idx, row_idx, busy, frame_done
   );
   modport slave (
      input  valid_in, clear,
      output valid_out_line, tree_en, valid_out, col_idx, row_idx, busy, frame_done
   );
endinterface

// File: rtl/control_maxpool_kxk_valid_pipe.sv
// control_valid_pipe: DEPTH-stage shift register carrying W-bit valid tags
// clk/rst (async active-low), clear (sync flush), d in, q[i] = d delayed i+1 cycles.
module control_valid_pipe #(
   parameter int DEPTH = 3,
   parameter int W     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [W-1:0]          d,
   output logic [DEPTH-1:0][W-1:0] q
);
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         q <= '0;
      else if (clear)
         q <= '0;
      else
         q <= {q[DEPTH-2:0], d};
endmodule

// File: rtl/control_maxpool_kxk.sv
// control_maxpool_kxk: raster-scan window/valid controller for a KxK stride-S max pool
// clk, rst (async active-low), bus (slave): valid_in/clear in; valid_out_line,
// tree_en, valid_out, col_idx/row_idx (next pixel), busy, frame_done out.
module control_maxpool_kxk
   import maxpool_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int K        = 3,
   parameter int STRIDE   = 1,
   parameter int TREE_LAT = DEF_TREE_LAT
) (
   input logic                  clk,
   input logic                  rst,
   control_maxpool_kxk_if.slave bus
);
   localparam int CW     = idx_w(WIDTH);
   localparam int RW     = idx_w(HEIGHT);
   localparam int PW     = idx_w(STRIDE);
   // Position of the final window; trailing partial strides never produce one.
   localparam int LAST_C = K - 1 + ((WIDTH - K) / STRIDE) * STRIDE;
   localparam int LAST_R = K - 1 + ((HEIGHT - K) / STRIDE) * STRIDE;
   state_t                    state;
   logic [CW-1:0]             col;
   logic [RW-1:0]             row;
   logic [PW-1:0]             col_ph, row_ph;
   logic                      col_end, row_end, hit, last, pend;
   logic [TREE_LAT:0][1:0]    pq;
   assign col_end = col == CW'(WIDTH - 1);
   assign row_end = row == RW'(HEIGHT - 1);
   // Phases are forced to zero on entering column/row K-1, so phase 0 marks a stride step.
   assign hit  = bus.valid_in && row >= RW'(K - 1) && col >= CW'(K - 1) && row_ph == '0 && col_ph == '0;
   assign last = hit && row == RW'(LAST_R) && col == CW'(LAST_C);
   // Anything still in flight besides the stage leaving as valid_out this cycle.
   assign pend = |pq[TREE_LAT-1:0];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= IDLE;
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
      end else if (bus.clear) begin
         state  <= IDLE;
         col    <= '0;
         row    <= '0;
         col_ph <= '0;
         row_ph <= '0;
      end else begin
         if (bus.valid_in) begin
            col    <= col_end ? '0 : col + 1'b1;
            col_ph <= (col_end || col == CW'(K - 2) || col_ph == PW'(STRIDE - 1)) ? '0 : col_ph + 1'b1;
            if (col_end) begin
               row    <= row_end ? '0 : row + 1'b1;
               row_ph <= (row_end || row == RW'(K - 2) || row_ph == PW'(STRIDE - 1)) ? '0 : row_ph + 1'b1;
            end
         end
         case (state)
            IDLE:    if (bus.valid_in) state <= FILL;
            FILL:    if (bus.valid_in && col_end && row == RW'(K - 2)) state <= RUN;
            RUN:     if (bus.valid_in && col_end && row_end) state <= DRAIN;
            default: state <= bus.valid_in ? FILL : (pend ? DRAIN : IDLE);
         endcase
      end
   control_valid_pipe #(.DEPTH(TREE_LAT + 1), .W(2)) u_pipe (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.clear),
      .d     ({last, hit}),
      .q     (pq)
   );
   always_comb begin
      bus.tree_en = '0;
      for (int i = 0; i < TREE_LAT; i++) bus.tree_en[i] = pq[i][0];
   end
   assign bus.valid_out_line = pq[0][0];
   assign bus.valid_out      = pq[TREE_LAT][0];
   assign bus.frame_done     = pq[TREE_LAT][1];
   assign bus.col_idx        = col;
   assign bus.row_idx        = row;
   assign bus.busy           = state != IDLE;
endmodule

// File: tb/tb_control_maxpool_kxk.sv
// tb_control_maxpool_kxk: three controller geometries on one shared pixel stream vs a behavioural model
module tb_control_maxpool_kxk;
   logic clk = 0, rst = 0, valid_in = 0, clear = 0;
   always #5 clk = ~clk;
   control_maxpool_kxk_if #(.WIDTH(5), .HEIGHT(5), .TREE_LAT(2)) ifa ();
   control_maxpool_kxk_if #(.WIDTH(4), .HEIGHT(4), .TREE_LAT(1)) ifb ();
   control_maxpool_kxk_if #(.WIDTH(6), .HEIGHT(6), .TREE_LAT(3)) ifc ();
   assign ifa.valid_in = valid_in;
   assign ifa.clear    = clear;
   assign ifb.valid_in = valid_in;
   assign ifb.clear    = clear;
   assign ifc.valid_in = valid_in;
   assign ifc.clear    = clear;
   control_maxpool_kxk #(.WIDTH(5), .HEIGHT(5), .K(3), .STRIDE(1), .TREE_LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   control_maxpool_kxk #(.WIDTH(4), .HEIGHT(4), .K(2), .STRIDE(2), .TREE_LAT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   control_maxpool_kxk #(.WIDTH(6), .HEIGHT(6), .K(3), .STRIDE(2), .TREE_LAT(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
   int pw[3] = '{5, 4, 6};
   int ph[3] = '{5, 4, 6};
   int pk[3] = '{3, 2, 3};
   int ps[3] = '{1, 2, 2};
   int pt[3] = '{2, 1, 3};
   string inst[3] = '{"A", "B", "C"};
   string nm[7] = '{"valid_out_line", "tree_en", "valid_out", "frame_done", "col_idx", "row_idx", "busy"};
   int checks = 0, errors = 0, cyc = 0;
   int n[3], hc[3];
   bit bz[3];
   bit hh[3][9], hl[3][9];
   int cnt_vo[3], cnt_vol[3], cnt_fd[3], fd_at[3];
   int fvo = -1, t12 = 0, bmask = 0;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask
   function automatic int nwin(input int i);
      return ((pw[i] - pk[i]) / ps[i] + 1) * ((ph[i] - pk[i]) / ps[i] + 1);
   endfunction
   always @(posedge clk) cyc++;
   // Model: pixel count per frame, window rule by plain arithmetic, delay line for latency.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            n[i] = 0; hc[i] = 0; bz[i] = 0;
            for (int j = 0; j < 9; j++) begin hh[i][j] = 0; hl[i][j] = 0; end
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            bit pend, hit, fin;
            int r, c;
            pend = 0;
            for (int j = 0; j < pt[i]; j++) pend |= hh[i][j];
            for (int j = 8; j > 0; j--) begin hh[i][j] = hh[i][j-1]; hl[i][j] = hl[i][j-1]; end
            hh[i][0] = 0; hl[i][0] = 0;
            if (clear) begin
               n[i] = 0; hc[i] = 0; bz[i] = 0;
               for (int j = 0; j < 9; j++) begin hh[i][j] = 0; hl[i][j] = 0; end
            end else begin
               fin = 0;
               if (valid_in) begin
                  r = n[i] / pw[i];
                  c = n[i] % pw[i];
                  hit = r >= pk[i] - 1 && c >= pk[i] - 1 && (r - pk[i] + 1) % ps[i] == 0 && (c - pk[i] + 1) % ps[i] == 0;
                  if (hit) hc[i]++;
                  hh[i][0] = hit;
                  hl[i][0] = hit && hc[i] == nwin(i);
                  n[i]++;
                  if (n[i] == pw[i] * ph[i]) begin n[i] = 0; hc[i] = 0; fin = 1; end
               end
               bz[i] = n[i] > 0 || fin || (bz[i] && pend);
            end
         end
      end
   end
   always @(negedge clk) begin
      int a[3][7];
      a[0] = '{int'(ifa.valid_out_line), int'(ifa.tree_en), int'(ifa.valid_out), int'(ifa.frame_done), int'(ifa.col_idx), int'(ifa.row_idx), int'(ifa.busy)};
      a[1] = '{int'(ifb.valid_out_line), int'(ifb.tree_en), int'(ifb.valid_out), int'(ifb.frame_done), int'(ifb.col_idx), int'(ifb.row_idx), int'(ifb.busy)};
      a[2] = '{int'(ifc.valid_out_line), int'(ifc.tree_en), int'(ifc.valid_out), int'(ifc.frame_done), int'(ifc.col_idx), int'(ifc.row_idx), int'(ifc.busy)};
      for (int i = 0; i < 3; i++) begin
         int e[7];
         int te;
         te = 0;
         for (int j = 0; j < pt[i]; j++) te |= int'(hh[i][j]) << j;
         e = '{int'(hh[i][0]), te, int'(hh[i][pt[i]]), int'(hl[i][pt[i]]), n[i] % pw[i], n[i] / pw[i], int'(bz[i])};
         for (int k = 0; k < 7; k++) chk($sformatf("%s.%s", inst[i], nm[k]), a[i][k], e[k]);
         cnt_vo[i] += a[i][2];
         cnt_vol[i] += a[i][0];
         if (a[i][3] != 0) begin cnt_fd[i]++; fd_at[i] = cnt_vo[i]; end
      end
      if (a[0][2] != 0 && fvo < 0) fvo = cyc;
      if (a[1][0] != 0) bmask |= 1 << (a[1][5] * 4 + a[1][4]);
   end
   task automatic px(input logic v, input logic c);
      @(posedge clk);
      #1;
      valid_in = v;
      clear = c;
   endtask
   task automatic zc();
      for (int i = 0; i < 3; i++) begin cnt_vo[i] = 0; cnt_vol[i] = 0; cnt_fd[i] = 0; fd_at[i] = 0; end
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      int got, it, drops;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_valid_out", int'(ifa.valid_out), 0);
      #1 rst = 1;
      zc();
      for (int k = 0; k < 25; k++) begin
         px(1, 0);
         if (k == 12) t12 = cyc;
      end
      repeat (8) px(0, 0);
      chk("A_frame_outputs", cnt_vo[0], 9);
      chk("A_frame_done_count", cnt_fd[0], 1);
      chk("A_frame_done_with_9th", fd_at[0], 9);
      chk("A_first_latency", fvo - t12, 3);
      chk("B_window_positions", bmask, 'h4141);
      chk("B_line_valid_count", cnt_vol[1], 6);
      px(0, 1);
      px(0, 0);
      zc();
      got = 0; it = 0;
      while (got < 36 && it < 1000) begin
         logic v;
         v = $urandom_range(0, 2) != 0;
         px(v, 0);
         got += int'(v);
         it++;
      end
      repeat (8) px(0, 0);
      chk("C_gap_frame_outputs", cnt_vo[2], 4);
      chk("C_gap_frame_done", cnt_fd[2], 1);
      px(0, 1);
      zc();
      drops = 0;
      for (int k = 0; k < 50; k++) begin
         px(1, 0);
         if (k > 0 && !ifa.busy) drops++;
      end
      repeat (8) px(0, 0);
      chk("A_b2b_outputs", cnt_vo[0], 18);
      chk("A_b2b_frame_done", cnt_fd[0], 2);
      chk("A_b2b_busy_drops", drops, 0);
      px(0, 1);
      for (int k = 0; k < 12; k++) px(1, 0);
      px(0, 0);
      #1 rst = 0;
      #1;
      chk("rst_mid_col_idx", int'(ifa.col_idx), 0);
      chk("rst_mid_row_idx", int'(ifa.row_idx), 0);
      chk("rst_mid_busy", int'(ifa.busy), 0);
      chk("rst_mid_tree_en", int'(ifa.tree_en), 0);
      chk("rst_mid_line", int'(ifa.valid_out_line), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1;
      zc();
      for (int k = 0; k < 25; k++) px(1, 0);
      repeat (8) px(0, 0);
      chk("A_after_rst_outputs", cnt_vo[0], 9);
      zc();
      for (int k = 0; k < 10; k++) px(1, 0);
      px(1, 1);
      px(0, 0);
      chk("abort_busy", int'(ifa.busy), 0);
      chk("abort_col_idx", int'(ifa.col_idx), 0);
      repeat (6) px(0, 0);
      chk("abort_outputs", cnt_vo[0], 0);
      px(1, 0);
      px(0, 0);
      chk("abort_restart_col", int'(ifa.col_idx), 1);
      for (int k = 0; k < 600; k++) px($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      repeat (8) px(0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
